// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: chain of STAGES skid-buffered register stages carrying a
// WIDTH-bit payload with valid/ready handshake, synchronous flush and a
// registered occupancy count. Every output is taken straight from a flop.
module pipe_stage_hs #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  output logic [$clog2(2*STAGES+1)-1:0]      occupancy
);

  localparam int            OW       = $clog2(2*STAGES+1);
  localparam logic [OW-1:0] OCC_MAX  = OW'(2*STAGES);
  localparam logic [OW-1:0] OCC_ONE  = OW'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state  [STAGES];
  logic [WIDTH-1:0] main_d [STAGES];
  logic [WIDTH-1:0] skid_d [STAGES];
  logic [WIDTH-1:0] up_d   [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] main_v;
  logic [STAGES-1:0] up_v;
  logic [STAGES-1:0] dn_r;
  logic [STAGES-1:0] push;
  logic [STAGES-1:0] pop;
  logic              in_hs;
  logic              out_hs;

  // Stage interconnect: stage k drains into stage k+1; ready is always a flop,
  // so out_ready never reaches in_ready combinationally.
  always_comb begin
    main_v = '0;
    up_v   = '0;
    dn_r   = '0;
    push   = '0;
    pop    = '0;
    for (int k = 0; k < STAGES; k++) begin
      main_v[k] = (state[k] != S_EMPTY);
    end
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      up_v[k] = main_v[k-1];
      up_d[k] = main_d[k-1];
    end
    for (int k = 0; k < STAGES-1; k++) begin
      dn_r[k] = rdy[k+1];
    end
    dn_r[STAGES-1] = out_ready;
    for (int k = 0; k < STAGES; k++) begin
      push[k] = up_v[k] & rdy[k];
      pop[k]  = main_v[k] & dn_r[k];
    end
  end

  assign in_hs     = in_valid & rdy[0];
  assign out_hs    = main_v[STAGES-1] & out_ready;
  assign in_ready  = rdy[0];
  assign out_valid = main_v[STAGES-1];
  assign out_data  = main_d[STAGES-1];

  // Per-stage FSM plus its registered upstream ready (low only when skid is full).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < STAGES; k++) begin
        state[k] <= S_EMPTY;
      end
      rdy <= reset ? '0 : '1;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        case (state[k])
          S_EMPTY: begin
            if (push[k]) state[k] <= S_ONE;
            rdy[k] <= 1'b1;
          end
          S_ONE: begin
            if (push[k] && !pop[k])      state[k] <= S_FULL;
            else if (!push[k] && pop[k]) state[k] <= S_EMPTY;
            rdy[k] <= !(push[k] && !pop[k]);
          end
          S_FULL: begin
            if (pop[k]) state[k] <= S_ONE;
            rdy[k] <= pop[k];
          end
          default: begin
            state[k] <= S_EMPTY;
            rdy[k]   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Payload movement: main loads from upstream or from skid; skid only catches
  // a push that arrives while main is held, so it is never overtaken.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < STAGES; k++) begin
        main_d[k] <= RESET_VAL;
        skid_d[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        case (state[k])
          S_EMPTY: begin
            if (push[k]) main_d[k] <= up_d[k];
          end
          S_ONE: begin
            if (push[k] && pop[k]) main_d[k] <= up_d[k];
            else if (push[k])      skid_d[k] <= up_d[k];
          end
          S_FULL: begin
            if (pop[k]) main_d[k] <= skid_d[k];
          end
          default: ;
        endcase
      end
    end
  end

  // Occupancy: entries accepted minus entries delivered; a flush-cycle pop
  // needs no special case because the count is cleared anyway.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_hs && !out_hs) begin
      occupancy <= occupancy + OCC_ONE;
    end else if (!in_hs && out_hs) begin
      occupancy <= occupancy - OCC_ONE;
    end
  end

  // Simulation guard on the occupancy bounds.
  always @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(in_hs && !out_hs && occupancy == OCC_MAX))
        else $error("pipe_stage_hs: occupancy overflow");
      assert (!(out_hs && !in_hs && occupancy == '0))
        else $error("pipe_stage_hs: occupancy underflow");
    end
  end

endmodule
